gen12_scramble_param: RTL and testbench

GEN12_SCRAMBLE_PARAM -- requirements
Module: gen12_scramble_param

---
 rtl/gen12_scramble_param.sv | 83 ++++++++
 tb/tb_gen12_scramble_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gen12_scramble_param.sv
// gen12_scramble_param: PCIe Gen1/2 multi-byte scrambler, 1-cycle latency, with COM/SKP/ordered-set handling.
module gen12_scramble_param #(
  parameter int MAX_BYTES = 4,
  parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [$clog2(MAX_BYTES):0] active_bytes_i,
  input  logic [8*MAX_BYTES-1:0]     data_i,
  input  logic [MAX_BYTES-1:0]       data_k_i,
  input  logic [MAX_BYTES-1:0]       data_os_i,
  input  logic                       data_valid_i,
  input  logic                       scramble_disable_i,
  output logic [8*MAX_BYTES-1:0]     data_o,
  output logic [MAX_BYTES-1:0]       data_k_o,
  output logic                       data_valid_o,
  output logic [15:0]                lfsr_o
);
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;

  logic [15:0]            lfsr_q;
  logic [15:0]            s;
  logic                   legal;
  logic [8*MAX_BYTES-1:0] d_n;
  logic [MAX_BYTES-1:0]   k_n;
  logic [7:0]             x;
  int                     n;

  function automatic logic [15:0] adv8(input logic [15:0] v);
    logic [15:0] t;
    t = v;
    for (int i = 0; i < 8; i++) t = {t[14:0], 1'b0} ^ (t[15] ? 16'h0039 : 16'h0000);
    return t;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Each lane sees the LFSR state left by the previous lane; inactive lanes leave it untouched.
  always_comb begin
    n = int'(active_bytes_i);
    legal = data_valid_i && (n == 1 || n == 2 || n == 4 || n == 8) && n <= MAX_BYTES;
    s = lfsr_q;
    d_n = '0;
    k_n = '0;
    x = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (legal && b < n) begin
        x = data_i[8*b +: 8];
        k_n[b] = data_k_i[b];
        if (data_k_i[b] && x == COM) begin
          d_n[8*b +: 8] = x;
          s = LFSR_SEED;
        end else if (data_k_i[b] && x == SKP) begin
          d_n[8*b +: 8] = x;
        end else begin
          d_n[8*b +: 8] = (data_k_i[b] || data_os_i[b] || scramble_disable_i) ? x : x ^ rev8(s[15:8]);
          s = adv8(s);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
      data_o <= '0;
      data_k_o <= '0;
      data_valid_o <= 1'b0;
    end else begin
      lfsr_q <= s;
      data_o <= d_n;
      data_k_o <= k_n;
      data_valid_o <= legal;
    end
  end

  assign lfsr_o = lfsr_q;
endmodule

// File: tb/tb_gen12_scramble_param.sv
// tb_gen12_scramble_param: random and directed stimulus checked every cycle against a bit-serial scrambler model.
module tb_gen12_scramble_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  active = 3'd4;
  logic [31:0] din = '0;
  logic [3:0]  kin = '0;
  logic [3:0]  osin = '0;
  logic        vin = 1'b0;
  logic        dis = 1'b0;
  logic [31:0] dout;
  logic [3:0]  kout;
  logic        vout;
  logic [15:0] lfsr;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] m_lfsr = 16'hFFFF;
  logic [31:0] e_d = '0;
  logic [3:0]  e_k = '0;
  logic        e_v = 1'b0;

  logic [7:0] zs [16] = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82,
                          8'h72, 8'h6E, 8'h28, 8'hA6, 8'hBE, 8'h6D, 8'hBF, 8'h8D};

  gen12_scramble_param #(.MAX_BYTES(4), .LFSR_SEED(16'hFFFF)) dut (
    .clk_i(clk), .rst_ni(rst_n), .active_bytes_i(active), .data_i(din), .data_k_i(kin),
    .data_os_i(osin), .data_valid_i(vin), .scramble_disable_i(dis),
    .data_o(dout), .data_k_o(kout), .data_valid_o(vout), .lfsr_o(lfsr)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: serial scrambler, one data bit against lfsr[15] per shift.
  function automatic logic [15:0] shift1(input logic [15:0] v);
    return v[15] ? ({v[14:0], 1'b0} ^ 16'h0039) : {v[14:0], 1'b0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr = 16'hFFFF;
      e_d = '0;
      e_k = '0;
      e_v = 1'b0;
    end else begin
      int n;
      logic [7:0] x;
      logic [7:0] o;
      n = int'(active);
      e_v = vin && (n == 1 || n == 2 || n == 4);
      e_d = '0;
      e_k = '0;
      if (e_v) begin
        for (int b = 0; b < n; b++) begin
          x = din[8*b +: 8];
          e_k[b] = kin[b];
          o = x;
          if (kin[b] && x == 8'hBC) m_lfsr = 16'hFFFF;
          else if (!(kin[b] && x == 8'h1C)) begin
            for (int i = 0; i < 8; i++) begin
              if (!(kin[b] || osin[b] || dis)) o[i] = x[i] ^ m_lfsr[15];
              m_lfsr = shift1(m_lfsr);
            end
          end
          e_d[8*b +: 8] = o;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("data_o", dout, e_d);
    chk("data_k_o", {28'd0, kout}, {28'd0, e_k});
    chk("data_valid_o", {31'd0, vout}, {31'd0, e_v});
    chk("lfsr_o", {16'd0, lfsr}, {16'd0, m_lfsr});
  end

  task automatic beat(input int n, input logic [31:0] d, input logic [3:0] k,
                      input logic [3:0] os, input logic ds, input logic v);
    active = 3'(n);
    din = d;
    kin = k;
    osin = os;
    dis = ds;
    vin = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int idx;
    int w;
    int widths [7] = '{1, 2, 1, 4, 4, 2, 2};
    logic [15:0] held;
    @(negedge clk);
    chk("reset data_o", dout, 32'h0);
    chk("reset valid", {31'd0, vout}, 32'h0);
    chk("reset lfsr", {16'd0, lfsr}, 32'h0000FFFF);
    rst_n = 1'b1;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      beat(4, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      for (int b = 0; b < 4; b++) begin
        chk("zero stream w4", {24'd0, dout[8*b +: 8]}, {24'd0, zs[idx]});
        idx++;
      end
    end
    do_reset();
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      w = widths[i];
      beat(w, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1);
      for (int b = 0; b < w; b++) begin
        chk("zero stream mixed", {24'd0, dout[8*b +: 8]}, {24'd0, zs[idx]});
        idx++;
      end
    end
    beat(4, 32'h0000_00BC, 4'b0001, 4'h0, 1'b0, 1'b1);
    chk("com beat", dout, 32'hC017_FFBC);
    beat(4, 32'h1C1C_1CBC, 4'b1111, 4'h0, 1'b0, 1'b1);
    chk("com skp passthrough", dout, 32'h1C1C_1CBC);
    chk("lfsr after com skp", {16'd0, lfsr}, 32'h0000FFFF);
    beat(1, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("d00 after skp", dout, 32'h0000_00FF);
    chk("lfsr after one byte", {16'd0, lfsr}, 32'h0000E817);
    beat(4, 32'h4A4A_4ABC, 4'b0001, 4'b1110, 1'b0, 1'b1);
    chk("ts1 first beat", dout, 32'h4A4A_4ABC);
    for (int i = 0; i < 3; i++) begin
      beat(4, 32'h4A4A_4A4A, 4'h0, 4'hF, 1'b0, 1'b1);
      chk("ts1 body", dout, 32'h4A4A_4A4A);
    end
    beat(1, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("d00 after ts1", dout, 32'h0000_008D);
    beat(4, 32'h1234_5678, 4'h0, 4'h0, 1'b1, 1'b1);
    chk("disable passthrough", dout, 32'h1234_5678);
    held = lfsr;
    beat(4, 32'hDEAD_BEEF, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("invalid data_o", dout, 32'h0);
    chk("invalid valid", {31'd0, vout}, 32'h0);
    chk("invalid lfsr held", {16'd0, lfsr}, {16'd0, held});
    beat(3, 32'hDEAD_BEEF, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("width3 valid", {31'd0, vout}, 32'h0);
    chk("width3 lfsr held", {16'd0, lfsr}, {16'd0, held});
    for (int c = 0; c < 600; c++) begin
      int ws [10] = '{1, 2, 4, 4, 4, 1, 2, 0, 3, 6};
      logic [31:0] d;
      logic [3:0] k;
      for (int b = 0; b < 4; b++) begin
        int r;
        r = int'($urandom_range(0, 9));
        k[b] = (r <= 2);
        d[8*b +: 8] = (r == 0) ? 8'hBC : (r == 1) ? 8'h1C : 8'($urandom);
      end
      if (c % 97 == 50) do_reset();
      beat(ws[$urandom_range(0, 9)] + (($urandom_range(0, 19) == 0) ? 1 : 0), d, k,
           4'($urandom) & 4'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) != 0));
    end
    vin = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
